// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity accumulator.
//   par_state_e : FSM encoding (IDLE / ACC / HOLD)
//   PAR_EVEN    : odd_mode value selecting an even-parity result bit
//   PAR_ODD     : odd_mode value selecting an odd-parity result bit
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } par_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_reduce.sv
// Purely combinational XOR-reduce of one DATA_W-bit beat to a single bit.
//   in_data : beat payload
//   par     : XOR of all DATA_W bits of in_data
module parity_reduce #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in_data,
  output logic              par
);

  assign par = ^in_data;

endmodule

// File: rtl/parity_stream_acc.sv
// Streaming parity accumulator: folds the parity of every accepted beat of a
// packet into one bit, counts the beats (saturating) and presents the result
// on a registered valid/ready output that blocks new input until consumed.
//   clk, rst                     : clock, synchronous active-high reset
//   odd_mode                     : parity sense, sampled on a packet's first beat
//   in_data/in_valid/in_last     : input beat stream
//   in_ready                     : high in IDLE and ACC, low while a result is held
//   par_out/par_beats/par_ovf    : packet parity bit, saturated beat count, overflow
//   par_valid/par_ready          : result handshake
module parity_stream_acc
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              par_out,
  output logic [CNT_W-1:0]  par_beats,
  output logic              par_ovf,
  output logic              par_valid,
  input  logic              par_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment; the caller flags overflow separately when c is at max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  par_state_e       state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mode_q, mode_d;
  logic             out_par_q, out_par_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_vld_q, out_vld_d;

  logic             beat_par;
  logic             accept;
  logic             first_beat;
  logic             acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base;
  logic             mode_cur;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_inc;

  parity_reduce #(.DATA_W(DATA_W)) u_reduce (
    .in_data (in_data),
    .par     (beat_par)
  );

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // A packet starting this cycle folds from a clean slate and takes the live
  // odd_mode; later beats use the mode latched on the first beat.
  assign first_beat = (state_q == IDLE);
  assign acc_base   = first_beat ? 1'b0 : acc_q;
  assign cnt_base   = first_beat ? '0 : cnt_q;
  assign ovf_base   = first_beat ? 1'b0 : ovf_q;
  assign mode_cur   = first_beat ? odd_mode : mode_q;
  assign cnt_inc    = sat_inc(cnt_base);
  assign ovf_inc    = ovf_base || (cnt_base == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    out_par_d   = out_par_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    out_vld_d   = out_vld_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (in_last) begin
            out_par_d   = acc_base ^ beat_par ^ mode_cur;
            out_beats_d = cnt_inc;
            out_ovf_d   = ovf_inc;
            out_vld_d   = 1'b1;
            acc_d       = 1'b0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = acc_base ^ beat_par;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_inc;
            mode_d  = mode_cur;
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (par_ready) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State / result register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= PAR_EVEN;
      out_par_q   <= 1'b0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      out_par_q   <= out_par_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
      out_vld_q   <= out_vld_d;
    end
  end

  assign par_out   = out_par_q;
  assign par_beats = out_beats_q;
  assign par_ovf   = out_ovf_q;
  assign par_valid = out_vld_q;

endmodule

// File: tb/tb_parity_stream_acc.sv
// Testbench for parity_stream_acc: two instances (CNT_W=8 and CNT_W=4) share
// one stimulus stream; expected results are queued per packet and popped on
// each output handshake.
module tb_parity_stream_acc;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       odd_mode = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       par_ready = 1'b0;

  logic       rdy8, pout8, povf8, pv8;
  logic [7:0] pb8;
  logic       rdy4, pout4, povf4, pv4;
  logic [3:0] pb4;

  int checks = 0;
  int failures = 0;
  logic rand_rdy = 1'b0;

  int   pkt_ones = 0;
  int   pkt_n = 0;
  logic pkt_mode = 1'b0;

  typedef struct {
    logic       p;
    logic [7:0] b8;
    logic       o8;
    logic [3:0] b4;
    logic       o4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  parity_stream_acc #(.DATA_W(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy8),
    .par_out(pout8), .par_beats(pb8), .par_ovf(povf8),
    .par_valid(pv8), .par_ready(par_ready)
  );

  parity_stream_acc #(.DATA_W(8), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy4),
    .par_out(pout4), .par_beats(pb4), .par_ovf(povf4),
    .par_valid(pv4), .par_ready(par_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Advance to just after the next rising edge; optionally randomise par_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) par_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat, wait for it to be accepted, then update the packet model.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic m);
    int   guard;
    logic taken;
    exp_t e;
    in_data  = d;
    in_last  = last;
    odd_mode = m;
    in_valid = 1'b1;
    guard    = 0;
    taken    = 1'b0;
    while (!taken) begin
      @(negedge clk);
      taken = rdy8;
      tick();
      guard++;
      if (!taken && guard > 500) begin
        check("accept_timeout", 32'd0, 32'd1);
        finish_tb();
      end
    end
    in_valid = 1'b0;
    if (pkt_n == 0) pkt_mode = m;
    pkt_ones += $countones(d);
    pkt_n++;
    if (last) begin
      e.p  = pkt_ones[0] ^ pkt_mode;
      e.b8 = (pkt_n > 255) ? 8'd255 : 8'(pkt_n);
      e.o8 = (pkt_n > 255);
      e.b4 = (pkt_n > 15) ? 4'd15 : 4'(pkt_n);
      e.o4 = (pkt_n > 15);
      sb.push_back(e);
      pkt_n    = 0;
      pkt_ones = 0;
    end
  endtask

  // Consume the held result with a one-cycle par_ready pulse.
  task automatic release_result();
    par_ready = 1'b1;
    @(negedge clk);
    tick();
    par_ready = 1'b0;
  endtask

  // Output-handshake monitor: pops the oldest expected packet and compares.
  always @(negedge clk) begin
    if (!rst && pv8 && par_ready) begin
      check("pv4_tracks_pv8", 32'(pv4), 32'd1);
      check("rdy_low_in_hold", 32'(rdy8), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd0, 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("par_out8", 32'(pout8), 32'(mon_e.p));
        check("par_out4", 32'(pout4), 32'(mon_e.p));
        check("par_beats8", 32'(pb8), 32'(mon_e.b8));
        check("par_ovf8", 32'(povf8), 32'(mon_e.o8));
        check("par_beats4", 32'(pb4), 32'(mon_e.b4));
        check("par_ovf4", 32'(povf4), 32'(mon_e.o4));
      end
    end
  end

  initial begin
    int len;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_pv", 32'(pv8), 32'd0);
    check("rst_pout", 32'(pout8), 32'd0);
    check("rst_beats", 32'(pb8), 32'd0);
    check("rst_ovf", 32'(povf8), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(rdy8), 32'd1);
    tick();

    // Single beat 0x07, even mode
    send_beat(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    check("single_pv", 32'(pv8), 32'd1);
    check("single_pout", 32'(pout8), 32'd1);
    check("single_beats", 32'(pb8), 32'd1);
    check("single_ovf", 32'(povf8), 32'd0);
    check("single_ready", 32'(rdy8), 32'd0);
    tick();

    // Backpressure: offered beat must not be taken while the result is held
    in_data  = 8'hAA;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_pv", 32'(pv8), 32'd1);
      check("bp_pout", 32'(pout8), 32'd1);
      check("bp_beats", 32'(pb8), 32'd1);
      check("bp_ready", 32'(rdy8), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    release_result();
    @(negedge clk);
    check("bp_pv_cleared", 32'(pv8), 32'd0);
    check("bp_ready_back", 32'(rdy8), 32'd1);
    tick();

    // Three beats, odd mode latched on first beat, toggled afterwards
    send_beat(8'h01, 1'b0, 1'b1);
    send_beat(8'h03, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    check("three_pout", 32'(pout8), 32'd0);
    check("three_beats", 32'(pb8), 32'd3);
    tick();
    release_result();

    // Saturation: 20 zero beats on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) send_beat(8'h00, (i == 19), 1'b0);
    @(negedge clk);
    check("sat_beats4", 32'(pb4), 32'd15);
    check("sat_ovf4", 32'(povf4), 32'd1);
    check("sat_pout4", 32'(pout4), 32'd0);
    check("sat_beats8", 32'(pb8), 32'd20);
    tick();
    release_result();
    send_beat(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("post_sat_ovf4", 32'(povf4), 32'd0);
    check("post_sat_beats4", 32'(pb4), 32'd1);
    tick();
    release_result();

    // Reset mid-packet discards the partial packet
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_pv", 32'(pv8), 32'd0);
    check("mid_rst_pout", 32'(pout8), 32'd0);
    check("mid_rst_beats", 32'(pb8), 32'd0);
    check("mid_rst_ovf", 32'(povf8), 32'd0);
    tick();
    rst      = 1'b0;
    pkt_n    = 0;
    pkt_ones = 0;
    @(negedge clk);
    check("mid_rst_ready", 32'(rdy8), 32'd1);
    tick();
    send_beat(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("after_rst_pout", 32'(pout8), 32'd0);
    check("after_rst_beats", 32'(pb8), 32'd1);
    tick();
    release_result();

    // Random packets with input bubbles and random result backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        send_beat(8'($urandom_range(0, 255)), (b == len - 1), 1'($urandom_range(0, 1)));
      end
    end
    rand_rdy  = 1'b0;
    par_ready = 1'b1;
    repeat (5) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("final_pv", 32'(pv8), 32'd0);
    finish_tb();
  end

endmodule
